// File: rtl/control_unit_if.sv
// Instruction-in / decoded-controls-out bundle between the instruction register and the datapath.
interface control_unit_if;
    logic [7:0] inst;
    logic [2:0] aluSel;
    logic [2:0] regInSel;
    logic [2:0] regOutSel;
    logic       regInEn;
    logic       regOutEn;
    logic       genConst;

    // Instruction source side
    modport master (
        output inst,
        input  aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst
    );

    // Decoder side
    modport slave (
        input  inst,
        output aluSel, regInSel, regOutSel, regInEn, regOutEn, genConst
    );
endinterface

// File: rtl/control_unit.sv
// Instruction decoder for the 8-bit CPU: combinational decode of inst, registered control outputs.
module control_unit (
    input  logic         clk,
    input  logic         rst,
    control_unit_if.slave bus
);
    localparam int unsigned INST_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned OPC_W  = INST_W - SEL_W;

    localparam logic [OPC_W-1:0] OPC_MOV_R0_RR = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_MOV_RR_R0 = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDC       = 5'b00011;

    typedef struct packed {
        logic [SEL_W-1:0] alu_sel;
        logic [SEL_W-1:0] reg_in_sel;
        logic [SEL_W-1:0] reg_out_sel;
        logic             reg_in_en;
        logic             reg_out_en;
        logic             gen_const;
    } ctrl_t;

    logic [OPC_W-1:0] opcode;
    logic [SEL_W-1:0] rrr;
    ctrl_t            ctrl_d;
    ctrl_t            ctrl_q;

    assign opcode = bus.inst[INST_W-1:SEL_W];
    assign rrr    = bus.inst[SEL_W-1:0];

    // Decode; undefined opcodes fall through to the all-zero NOP default
    always_comb begin
        ctrl_d = '0;
        casez (opcode)
            OPC_MOV_R0_RR: begin
                ctrl_d.reg_out_sel = rrr;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.reg_in_en   = 1'b1;
            end
            OPC_MOV_RR_R0: begin
                ctrl_d.reg_in_sel = rrr;
                ctrl_d.reg_out_en = 1'b1;
                ctrl_d.reg_in_en  = 1'b1;
            end
            OPC_LDC: begin
                ctrl_d.gen_const  = 1'b1;
                ctrl_d.reg_in_sel = rrr;
                ctrl_d.reg_in_en  = 1'b1;
            end
            5'b01???: begin
                ctrl_d.alu_sel     = opcode[SEL_W-1:0];
                ctrl_d.reg_out_sel = rrr;
                ctrl_d.reg_out_en  = 1'b1;
                ctrl_d.reg_in_en   = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.aluSel    = ctrl_q.alu_sel;
    assign bus.regInSel  = ctrl_q.reg_in_sel;
    assign bus.regOutSel = ctrl_q.reg_out_sel;
    assign bus.regInEn   = ctrl_q.reg_in_en;
    assign bus.regOutEn  = ctrl_q.reg_out_en;
    assign bus.genConst  = ctrl_q.gen_const;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed cases plus randomized instructions against a reference decode.
module tb_control_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    control_unit_if cu_if ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (cu_if)
    );

    always #5 clk = ~clk;

    // Packed view: {alu[11:9], in[8:6], out[5:3], in_en, out_en, gen}
    function automatic logic [11:0] pack(input int alu, input int rin, input int rout,
                                         input int in_en, input int out_en, input int gen);
        return {3'(alu), 3'(rin), 3'(rout), 1'(in_en), 1'(out_en), 1'(gen)};
    endfunction

    function automatic logic [11:0] observed();
        return {cu_if.aluSel, cu_if.regInSel, cu_if.regOutSel,
                cu_if.regInEn, cu_if.regOutEn, cu_if.genConst};
    endfunction

    function automatic logic [11:0] ref_decode(input logic [7:0] i);
        int op;
        int r;
        op = int'(i) / 8;
        r  = int'(i) % 8;
        if (op == 1)                 return pack(0, 0, r, 1, 1, 0);
        else if (op == 2)            return pack(0, r, 0, 1, 1, 0);
        else if (op == 3)            return pack(0, r, 0, 1, 0, 1);
        else if (op >= 8 && op < 16) return pack(op - 8, 0, r, 1, 1, 0);
        return 12'h000;
    endfunction

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
        end
    endtask

    // Drive inst at the falling edge, then sample just after the next rising edge
    task automatic apply(input logic [7:0] i);
        @(negedge clk);
        cu_if.inst = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] r_inst;
        logic [11:0] exp_v;
        clk    = 1'b0;
        rst    = 1'b0;
        checks = 0;
        errors = 0;
        cu_if.inst = 8'hFF;

        // Held in reset with an active-looking instruction
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_eq("reset_hold_pos", observed(), 12'h000);
            @(negedge clk); #1;
            check_eq("reset_hold_neg", observed(), 12'h000);
        end

        @(negedge clk);
        rst = 1'b1;
        apply(8'h00);
        check_eq("nop", observed(), 12'h000);

        apply(8'b00001_011);
        check_eq("mov_r0_rr", observed(), pack(0, 0, 3, 1, 1, 0));

        apply(8'b00011_101);
        check_eq("ldc", observed(), pack(0, 5, 0, 1, 0, 1));

        apply(8'b01110_010);
        check_eq("alu6", observed(), pack(6, 0, 2, 1, 1, 0));

        // Asynchronous clear between edges
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_clear", observed(), 12'h000);

        @(negedge clk);
        rst = 1'b1;
        apply(8'hFF);
        check_eq("undef_ff", observed(), 12'h000);

        apply(8'b00010_110);
        check_eq("mov_rr_r0", observed(), pack(0, 6, 0, 1, 1, 0));

        apply(8'b00101_111);
        check_eq("undef_00101", observed(), 12'h000);

        // Reset release coincident with an instruction change
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("clear_again", observed(), 12'h000);
        @(negedge clk);
        rst = 1'b1;
        cu_if.inst = 8'b01011_100;
        @(posedge clk); #1;
        check_eq("release_load", observed(), pack(3, 0, 4, 1, 1, 0));

        // Randomized instructions with occasional mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            r_inst = 8'($urandom_range(0, 255));
            apply(r_inst);
            exp_v = ref_decode(r_inst);
            check_eq("rand_decode", observed(), exp_v);
            checks++;
            if (cu_if.genConst && cu_if.regOutEn) begin
                errors++;
                $display("FAIL excl_gen_out inst=%02h genConst=%0b regOutEn=%0b",
                         r_inst, cu_if.genConst, cu_if.regOutEn);
            end
            @(negedge clk); #1;
            check_eq("rand_stable", observed(), exp_v);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                #1;
                check_eq("rand_async_clear", observed(), 12'h000);
                #1;
                rst = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
